// File: rtl/t05_pkg.sv
// Shared types and constants for the bitstream arbiter slice.
package t05_pkg;
    localparam int BYTE_W = 8;
    localparam int POS_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CW,
        FLUSH,
        DONE
    } t05_arb_state_t;
endpackage

// File: rtl/t05_byte_fifo.sv
// Byte FIFO between the packer and the consumer. Head entry is shown
// combinationally; output reads as zero while empty so reset leaves dout at 0.
module t05_byte_fifo
    import t05_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == L_FULL);
    // A pop frees the slot this same cycle, so a push into a full FIFO still lands.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = empty ? '0 : r_mem[r_rd];

    // Storage write; contents need no reset since empty masks the output.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/t05_bitstream_arbiter.sv
// Arbitrates header and codeword bit writers onto one MSB-first byte stream,
// with an end-of-file pad/flush handshake and a small output FIFO.
module t05_bitstream_arbiter
    import t05_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hdr_req,
    input  logic              hdr_en,
    input  logic              hdr_bit,
    input  logic              hdr_done,
    output logic              hdr_gnt,
    input  logic              cw_req,
    input  logic              cw_en,
    input  logic              cw_bit,
    input  logic              cw_done,
    output logic              cw_gnt,
    input  logic              flush,
    output logic              flush_done,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              overflow,
    output logic [15:0]       bit_count
);
    t05_arb_state_t    r_state;
    logic              r_hdr_gnt;
    logic              r_cw_gnt;
    logic              r_flush_done;
    logic [POS_W-1:0]  r_pos;
    logic [BYTE_W-1:0] r_shift;
    logic              r_overflow;
    logic [15:0]       r_bit_count;

    logic              w_acc;
    logic              w_bit;
    logic [BYTE_W-1:0] w_fill;
    logic              w_push;
    logic [BYTE_W-1:0] w_din;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic              w_in_flush;

    assign w_in_flush = (r_state == FLUSH);

    // Only the current owner's strobe counts; the other writer is ignored.
    always_comb begin
        w_acc = 1'b0;
        w_bit = 1'b0;
        if (r_state == HDR) begin
            w_acc = hdr_en;
            w_bit = hdr_bit;
        end else if (r_state == CW) begin
            w_acc = cw_en;
            w_bit = cw_bit;
        end
    end

    // Drop the incoming bit into the partial byte at the MSB-first position.
    always_comb begin
        w_fill = r_shift;
        w_fill[POS_W'(BYTE_W-1) - r_pos] = w_bit;
    end

    // Push on the 8th bit, or the zero-padded partial byte while flushing.
    assign w_push = (w_acc && (r_pos == POS_W'(BYTE_W-1))) ||
                    (w_in_flush && (r_pos != '0));
    assign w_din  = w_in_flush ? r_shift : w_fill;
    assign w_pop  = !w_empty && byte_ready;

    t05_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (byte_out),
        .empty (w_empty),
        .full  (w_full)
    );

    // Packer: partial byte survives ownership changes, cleared on push/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos   <= '0;
            r_shift <= '0;
        end else if (w_in_flush) begin
            r_pos   <= '0;
            r_shift <= '0;
        end else if (w_acc) begin
            r_pos   <= r_pos + 1'b1;
            r_shift <= (r_pos == POS_W'(BYTE_W-1)) ? '0 : w_fill;
        end
    end

    // Sticky drop flag and saturating accepted-bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_bit_count <= '0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_acc && (r_bit_count != 16'hFFFF)) r_bit_count <= r_bit_count + 1'b1;
        end
    end

    // Ownership FSM with registered grants; only done releases a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hdr_gnt    <= 1'b0;
            r_cw_gnt     <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hdr_req) begin
                        r_state   <= HDR;
                        r_hdr_gnt <= 1'b1;
                    end else if (cw_req) begin
                        r_state  <= CW;
                        r_cw_gnt <= 1'b1;
                    end else if (flush) begin
                        r_state <= FLUSH;
                    end
                end
                HDR: begin
                    if (hdr_done) begin
                        r_state   <= IDLE;
                        r_hdr_gnt <= 1'b0;
                    end
                end
                CW: begin
                    if (cw_done) begin
                        r_state  <= IDLE;
                        r_cw_gnt <= 1'b0;
                    end
                end
                FLUSH: r_state <= DONE;
                DONE: begin
                    if (w_empty) begin
                        r_state      <= IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_hdr_gnt <= 1'b0;
                    r_cw_gnt  <= 1'b0;
                end
            endcase
        end
    end

    assign hdr_gnt    = r_hdr_gnt;
    assign cw_gnt     = r_cw_gnt;
    assign flush_done = r_flush_done;
    assign byte_valid = !w_empty;
    assign overflow   = r_overflow;
    assign bit_count  = r_bit_count;
endmodule

// File: tb/tb_t05_bitstream_arbiter.sv
// Directed bench: table of header/codeword streams with expected bytes,
// plus hand sequences for arbitration, overflow and mid-burst reset.
module tb_t05_bitstream_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        hdr_req, hdr_en, hdr_bit, hdr_done, hdr_gnt;
    logic        cw_req, cw_en, cw_bit, cw_done, cw_gnt;
    logic        flush, flush_done;
    logic [7:0]  byte_out;
    logic        byte_valid, byte_ready, overflow;
    logic [15:0] bit_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] cap[$];

    t05_bitstream_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .hdr_req(hdr_req), .hdr_en(hdr_en), .hdr_bit(hdr_bit), .hdr_done(hdr_done), .hdr_gnt(hdr_gnt),
        .cw_req(cw_req), .cw_en(cw_en), .cw_bit(cw_bit), .cw_done(cw_done), .cw_gnt(cw_gnt),
        .flush(flush), .flush_done(flush_done),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .overflow(overflow), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Record each byte the consumer will take on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) cap.push_back(byte_out);
    end

    typedef struct {
        int               hn;
        logic [63:0]      hb;
        int               cn;
        logic [63:0]      cb;
        int               nb;
        logic [3:0][7:0]  eb;
        int               bc;
    } vec_t;
    vec_t tv[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        cap.delete();
    endtask

    task automatic send(input bit is_hdr, input int n, input logic [63:0] bits);
        int g;
        if (n == 0) return;
        if (is_hdr) hdr_req = 1'b1; else cw_req = 1'b1;
        g = 0;
        do begin
            tick;
            g++;
        end while (!(is_hdr ? hdr_gnt : cw_gnt) && g < 20);
        chk(is_hdr ? "hdr_grant" : "cw_grant", is_hdr ? hdr_gnt : cw_gnt, 1);
        hdr_req = 1'b0;
        cw_req  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (is_hdr) begin
                hdr_en = 1'b1; hdr_bit = bits[n-1-i]; hdr_done = (i == n-1);
            end else begin
                cw_en = 1'b1; cw_bit = bits[n-1-i]; cw_done = (i == n-1);
            end
            tick;
        end
        hdr_en = 1'b0; hdr_bit = 1'b0; hdr_done = 1'b0;
        cw_en  = 1'b0; cw_bit  = 1'b0; cw_done  = 1'b0;
    endtask

    task automatic do_flush(input int exp_n);
        int g;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        g = 0;
        while (!flush_done && g < 100) begin
            tick;
            g++;
        end
        chk("flush_done", flush_done, 1);
        chk("bytes_at_flush_done", cap.size(), exp_n);
        tick;
        chk("flush_done_pulse", flush_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        hdr_req = 0; hdr_en = 0; hdr_bit = 0; hdr_done = 0;
        cw_req = 0; cw_en = 0; cw_bit = 0; cw_done = 0;
        flush = 0; byte_ready = 1'b1;

        tv[0] = '{9,  64'h141,  3,  64'h5,   2, {8'h00, 8'h00, 8'hD0, 8'hA0}, 12};
        tv[1] = '{16, 64'hA55A, 0,  64'h0,   2, {8'h00, 8'h00, 8'h5A, 8'hA5}, 16};
        tv[2] = '{0,  64'h0,    8,  64'h3C,  1, {8'h00, 8'h00, 8'h00, 8'h3C}, 8};
        tv[3] = '{4,  64'hF,    4,  64'h1,   1, {8'h00, 8'h00, 8'h00, 8'hF1}, 8};
        tv[4] = '{3,  64'h3,    0,  64'h0,   1, {8'h00, 8'h00, 8'h00, 8'h60}, 3};
        tv[5] = '{0,  64'h0,    0,  64'h0,   0, {8'h00, 8'h00, 8'h00, 8'h00}, 0};
        tv[6] = '{1,  64'h1,    10, 64'h2AB, 2, {8'h00, 8'h00, 8'h60, 8'hD5}, 11};

        // Reset state.
        do_reset;
        chk("rst_hdr_gnt", hdr_gnt, 0);
        chk("rst_cw_gnt", cw_gnt, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_overflow", overflow, 0);
        chk("rst_bit_count", bit_count, 0);

        // Stream table.
        for (int t = 0; t < 7; t++) begin
            do_reset;
            send(1'b1, tv[t].hn, tv[t].hb);
            send(1'b0, tv[t].cn, tv[t].cb);
            do_flush(tv[t].nb);
            for (int k = 0; k < tv[t].nb; k++)
                chk($sformatf("vec%0d_byte%0d", t, k), (k < cap.size()) ? cap[k] : 8'hxx, tv[t].eb[k]);
            chk($sformatf("vec%0d_bit_count", t), bit_count, tv[t].bc);
            chk($sformatf("vec%0d_overflow", t), overflow, 0);
        end

        // Priority, non-owner strobe, grant hold without done.
        do_reset;
        hdr_req = 1'b1; cw_req = 1'b1;
        tick;
        chk("prio_hdr_gnt", hdr_gnt, 1);
        chk("prio_cw_gnt", cw_gnt, 0);
        hdr_req = 1'b0;
        cw_en = 1'b1; cw_bit = 1'b1;
        tick;
        cw_en = 1'b0; cw_bit = 1'b0;
        chk("nonowner_bit_count", bit_count, 0);
        chk("hdr_held_no_done", hdr_gnt, 1);
        hdr_en = 1'b1; hdr_bit = 1'b1; hdr_done = 1'b1;
        tick;
        hdr_en = 1'b0; hdr_bit = 1'b0; hdr_done = 1'b0;
        chk("done_bit_accepted", bit_count, 1);
        chk("idle_hdr_gnt", hdr_gnt, 0);
        chk("idle_cw_gnt", cw_gnt, 0);
        tick;
        chk("cw_gnt_after_idle", cw_gnt, 1);
        chk("hdr_gnt_low_in_cw", hdr_gnt, 0);
        cw_req = 1'b0;
        tick;
        tick;
        chk("cw_held_req_dropped", cw_gnt, 1);
        cw_done = 1'b1;
        tick;
        cw_done = 1'b0;
        chk("cw_released", cw_gnt, 0);

        // Overflow with consumer stalled.
        do_reset;
        byte_ready = 1'b0;
        send(1'b1, 40, 64'hFF_FFFF_FFFF);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", byte_valid, 1);
        chk("ovf_bit_count", bit_count, 40);
        byte_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        chk("ovf_bytes", cap.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("ovf_byte%0d", k), (k < cap.size()) ? cap[k] : 8'hxx, 8'hFF);
        chk("ovf_drained", byte_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-header with a buffered byte and a partial byte.
        do_reset;
        byte_ready = 1'b0;
        hdr_req = 1'b1;
        tick;
        hdr_req = 1'b0;
        for (int i = 0; i < 13; i++) begin
            hdr_en = 1'b1; hdr_bit = 1'b1;
            tick;
        end
        hdr_en = 1'b0; hdr_bit = 1'b0;
        chk("pre_rst_valid", byte_valid, 1);
        chk("pre_rst_gnt", hdr_gnt, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", hdr_gnt, 0);
        chk("async_rst_valid", byte_valid, 0);
        chk("async_rst_byte_out", byte_out, 8'h00);
        chk("async_rst_bit_count", bit_count, 0);
        tick;
        rst = 1'b0;
        byte_ready = 1'b1;
        cap.delete();
        do_flush(0);
        chk("post_rst_bit_count", bit_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
